// File: rtl/btc_job_loader.sv
// Header-word loader: buffers a 20-word block header, then streams it to the SHA core with ready/valid.
// Build option JOB_LOADER_NONCE_INC_EN: bump word 19 after each job and keep the mask so restart needs no rewrite.
module btc_job_loader (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic        core_ready,
  output logic        core_valid,
  output logic [31:0] core_word,
  output logic        core_last,
  output logic        busy,
  output logic        err,
  output logic [15:0] status_io
);

  // state  | meaning
  // IDLE   | accepting header writes, waiting for start
  // STREAM | offering buffer[index] to the core
  // DONE   | one-cycle wrap-up before returning to IDLE
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [4:0]  LAST_IDX    = 5'd19;
  localparam logic [15:0] ST_FEED     = 16'hFEED;
  localparam logic [15:0] ST_DEAD     = 16'hDEAD;
  localparam logic [15:0] ST_BAD      = 16'hBAD0;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [19:0] r_mask;
  logic [31:0] r_buf [0:19];
  logic        r_core_valid;
  logic [31:0] r_core_word;
  logic        r_core_last;
  logic        r_busy;
  logic        r_err;
  logic [15:0] r_status;

  logic        w_addr_ok;
  logic        w_wr_ok;
  logic        w_mask_full;
  logic [4:0]  w_idx_nxt;

  assign w_addr_ok   = (wr_addr <= LAST_IDX);
  assign w_wr_ok     = wr_en && (r_state == S_IDLE) && w_addr_ok;
  assign w_mask_full = &r_mask;
  assign w_idx_nxt   = r_idx + 5'd1;

  // Buffer has no reset: a partial job is discarded through the mask instead.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
`ifdef JOB_LOADER_NONCE_INC_EN
    else if (r_state == S_DONE) begin
      r_buf[LAST_IDX] <= r_buf[LAST_IDX] + 32'd1;
    end
`endif
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 5'd0;
      r_mask       <= 20'd0;
      r_core_valid <= 1'b0;
      r_core_word  <= 32'd0;
      r_core_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_status     <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wr_en && !w_addr_ok) begin
            r_err <= 1'b1;
          end
          if (w_wr_ok) begin
            r_mask[wr_addr] <= 1'b1;
          end
          if (start) begin
            if (w_mask_full) begin
              r_state      <= S_STREAM;
              r_busy       <= 1'b1;
              r_idx        <= 5'd0;
              r_core_valid <= 1'b1;
              r_core_word  <= r_buf[0];
              r_core_last  <= 1'b0;
              r_status     <= ST_FEED;
            end else begin
              r_err    <= 1'b1;
              r_status <= ST_BAD;
            end
          end
        end
        S_STREAM: begin
          if (wr_en || start) begin
            r_err <= 1'b1;
          end
          // core_valid is always high here, so ready alone marks a transfer
          if (core_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state      <= S_DONE;
              r_core_valid <= 1'b0;
              r_core_last  <= 1'b0;
              r_status     <= ST_DEAD;
            end else begin
              r_idx       <= w_idx_nxt;
              r_core_word <= r_buf[w_idx_nxt];
              r_core_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          if (wr_en || start) begin
            r_err <= 1'b1;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= 5'd0;
`ifndef JOB_LOADER_NONCE_INC_EN
          r_mask  <= 20'd0;
`endif
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_core_valid <= 1'b0;
          r_core_last  <= 1'b0;
        end
      endcase
    end
  end

  assign core_valid = r_core_valid;
  assign core_word  = r_core_word;
  assign core_last  = r_core_last;
  assign busy       = r_busy;
  assign err        = r_err;
  assign status_io  = r_status;

endmodule

// File: doc/btc_job_loader.md
BTC_JOB_LOADER -- requirements
Module: btc_job_loader

Interface
REQ-001 SHALL have port wb_clk_i, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port wr_en, input, 1: header-word write strobe from the Wishbone slave decoder.
REQ-004 SHALL have port wr_addr, input, 5: header word index 0..19.
REQ-005 SHALL have port wr_data, input, 32: header word value.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that commits the job.
REQ-007 SHALL have port core_ready, input, 1: SHA core accepts a word.
REQ-008 SHALL have port core_valid, output, 1: core_word is valid.
REQ-009 SHALL have port core_word, output, 32: header word being offered.
REQ-010 SHALL have port core_last, output, 1: offered word is index 19.
REQ-011 SHALL have port busy, output, 1: state is not IDLE.
REQ-012 SHALL have port err, output, 1: sticky error flag.
REQ-013 SHALL have port status_io, output, 16: progress code driven to mprj_io[31:16].

Function
REQ-014 SHALL hold a 20 x 32-bit header buffer plus a 20-bit written mask.
REQ-015 SHALL write wr_data into buffer[wr_addr] and set mask[wr_addr] when wr_en=1, state=IDLE and wr_addr<=19.
REQ-016 SHALL ignore a write with wr_addr>=20 and set err.
REQ-017 SHALL ignore a write while busy=1, leaving buffer and mask unchanged, and set err.
REQ-018 SHALL implement the states IDLE, STREAM and DONE.
REQ-019 SHALL move from IDLE to STREAM on start=1 with mask all-ones, clearing the word index to 0.
REQ-020 SHALL, on start=1 with an incomplete mask, stay in IDLE, set err and set status_io=16'hBAD0.
REQ-021 SHALL ignore start while in STREAM or DONE and set err.
REQ-022 SHALL, in STREAM, drive core_valid=1, core_word=buffer[index] and core_last=(index==19), all registered.
REQ-023 SHALL transfer a word on any cycle where core_valid=1 and core_ready=1; the index then increments.
REQ-024 SHALL keep core_valid and core_word stable until the transfer occurs, so no word is dropped or duplicated under back-pressure.
REQ-025 SHALL move to DONE on the transfer of index 19, deasserting core_valid on the next cycle.
REQ-026 SHALL stay in DONE for exactly one cycle, then enter IDLE.
REQ-027 SHALL clear the mask on the DONE to IDLE transition, unless JOB_LOADER_NONCE_INC_EN is defined.
REQ-028 SHALL set status_io=16'hFEED on IDLE to STREAM and status_io=16'hDEAD on entering DONE; status_io holds until the next such event or reset.
REQ-029 SHALL latch the first core word 1 cycle after start; 20 uninterrupted transfers take 20 cycles.
REQ-030 SHALL keep err set until reset; err has no effect on streaming.

Reset
REQ-031 SHALL, while rst_n=0, set state IDLE, index 0, mask 0, core_valid=0, core_last=0, core_word=0, busy=0, err=0 and status_io=16'h0000.
REQ-032 SHALL, when rst_n asserts mid-STREAM, abort immediately with core_valid low and discard the partial job; buffer contents need not be cleared.

Configuration
REQ-033 SHALL, with JOB_LOADER_NONCE_INC_EN defined, on DONE increment buffer[19] by 1 modulo 2^32 (FFFFFFFF wraps to 00000000) and retain the mask, so that a new start restreams with no rewrite.
REQ-034 SHALL, without JOB_LOADER_NONCE_INC_EN, leave buffer[19] unchanged and clear the mask on DONE.

Verification
REQ-035 SHALL cover: write words 0..19 = 0x1000+i, start, core_ready=1 -> 20 words 0x1000..0x1013 on consecutive cycles, core_last only on 0x1013, status_io FEED then DEAD, busy low 2 cycles after the last transfer.
REQ-036 SHALL cover: same job, core_ready toggling 1,0,0,1,... -> word order unchanged, no drop or duplicate, core_word stable while core_ready=0.
REQ-037 SHALL cover: write words 0..18 only, start -> no core_valid, err=1, status_io=BAD0.
REQ-038 SHALL cover: wr_en during STREAM at addr 5 -> buffer[5] unchanged in the stream, err=1; start during STREAM -> ignored.
REQ-039 SHALL cover: rst_n low after 7 transfers -> core_valid=0 and status_io=0000 asynchronously; a fresh job afterwards streams normally.
REQ-040 SHALL cover, with JOB_LOADER_NONCE_INC_EN: word19=FFFFFFFF, two starts -> first stream last word FFFFFFFF, second stream last word 00000000, no err.
